// File: rtl/srl_delay_ctrl_if.sv
// Handshake bundle for srl_delay_ctrl: delay configuration, input sample stream
// and delayed output stream. The slave modport is the controller's view.
`timescale 1ns/1ps
interface srl_delay_ctrl_if #(
  parameter int N = 32,
  parameter int W = 8
);
  logic                 cfg_valid;
  logic [$clog2(N)-1:0] cfg_delay;
  logic                 cfg_clear;
  logic                 cfg_ready;
  logic                 s_valid;
  logic [W-1:0]         s_data;
  logic                 s_ready;
  logic                 m_valid;
  logic [W-1:0]         m_data;
  logic                 m_ready;

  modport master (
    output cfg_valid, cfg_delay, cfg_clear, s_valid, s_data, m_ready,
    input  cfg_ready, s_ready, m_valid, m_data
  );

  modport slave (
    input  cfg_valid, cfg_delay, cfg_clear, s_valid, s_data, m_ready,
    output cfg_ready, s_ready, m_valid, m_data
  );
endinterface

// File: rtl/srl_delay_ctrl.sv
// Controller for an external shift-register delay line with a variable tap.
// Scrubs the line after reset or on request, then streams samples with delay D+1.
`timescale 1ns/1ps
module srl_delay_ctrl #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  srl_delay_ctrl_if.slave        bus,
  output logic                   srl_en,
  output logic [$clog2(N)-1:0]   srl_sel,
  output logic [W-1:0]           srl_din,
  input  logic [W-1:0]           srl_dout,
  output logic [$clog2(N+1)-1:0] fill,
  output logic                   busy
);

  localparam int DW = $clog2(N);
  localparam int FW = $clog2(N+1);
  localparam logic [DW-1:0] CLR_LAST = DW'(N - 1);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] clr_cnt_q, clr_cnt_d;
  logic [DW-1:0] delay_q, delay_d;
  logic [FW-1:0] fill_q, fill_d;

  logic          is_run;
  logic [FW-1:0] depth;
  logic          full;
  logic          cfg_hs;
  logic          s_rdy;
  logic          push;

  // The SRL has no pop: an output leaves only when a new sample shifts in.
  assign is_run = (state_q == RUN);
  assign depth  = FW'(delay_q) + FW'(1);
  assign full   = (fill_q == depth);
  assign cfg_hs = is_run && bus.cfg_valid;
  assign s_rdy  = is_run && !bus.cfg_valid && ((fill_q <= FW'(delay_q)) || bus.m_ready);
  assign push   = bus.s_valid && s_rdy;

  assign bus.cfg_ready = is_run;
  assign bus.s_ready   = s_rdy;
  assign bus.m_valid   = is_run && !bus.cfg_valid && full && bus.s_valid;
  assign bus.m_data    = srl_dout;

  assign srl_en  = !is_run || push;
  assign srl_din = push ? bus.s_data : '0;
  assign srl_sel = delay_q;
  assign fill    = fill_q;
  assign busy    = !is_run;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    delay_d   = delay_q;
    fill_d    = fill_q;
    case (state_q)
      CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          clr_cnt_d = '0;
          state_d   = RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + DW'(1);
        end
      end
      RUN: begin
        // A new configuration discards everything held, scrubbed or not.
        if (cfg_hs) begin
          delay_d = bus.cfg_delay;
          fill_d  = '0;
          if (bus.cfg_clear) state_d = CLEAR;
        end else if (push && !full) begin
          fill_d = fill_q + FW'(1);
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      delay_q   <= '0;
      fill_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      delay_q   <= delay_d;
      fill_q    <= fill_d;
    end
  end

endmodule
